// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle main controller for the MIPS-subset CPU.
// Sequences fetch, decode and the per-class execute/writeback steps, drives
// the datapath mux selects and enables, and guards every memory access with
// a request/acknowledge handshake plus a wait-cycle timeout.
module mc_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       reg_we,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       alu_srca,
    output logic [1:0] alu_srcb,
    output logic [2:0] alu_op,
    output logic [3:0] state_o,
    output logic       bus_err,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IMMEX  = 4'd10,
        S_IMMWB  = 4'd11,
        S_JR     = 4'd12,
        S_ERR    = 4'd15
    } state_t;

    // Instruction opcodes (IR[31:26]).
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // R-type function codes (IR[5:0]).
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    // Datapath select encodings.
    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;
    localparam logic [1:0] PCSRC_RS     = 2'd3;

    localparam logic [1:0] DST_RT = 2'd0;
    localparam logic [1:0] DST_RD = 2'd1;
    localparam logic [1:0] DST_RA = 2'd2;

    localparam logic [1:0] WB_ALUOUT = 2'd0;
    localparam logic [1:0] WB_MDR    = 2'd1;
    localparam logic [1:0] WB_PC     = 2'd2;

    localparam logic [1:0] SRCB_RT    = 2'd0;
    localparam logic [1:0] SRCB_FOUR  = 2'd1;
    localparam logic [1:0] SRCB_IMM   = 2'd2;
    localparam logic [1:0] SRCB_IMMSH = 2'd3;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_FUNCT = 3'd2;
    localparam logic [2:0] ALU_OR    = 3'd3;

    localparam logic [15:0] TIMEOUT_LIMIT = 16'(MEM_TIMEOUT);

    state_t      state;
    logic [15:0] wait_cnt;
    logic [15:0] wait_inc;
    logic        waiting;
    logic        timeout_hit;
    logic        funct_alu;

    // Request states hold mem_req high; the counter tracks unacknowledged cycles
    // there, and the timeout fires on the cycle the count would reach the limit.
    assign waiting     = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    assign wait_inc    = wait_cnt + 16'd1;
    assign timeout_hit = waiting && !mem_ack && (wait_inc == TIMEOUT_LIMIT);
    assign funct_alu   = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                         (funct == FN_OR)  || (funct == FN_SLT);

    assign state_o = state;

    // State register, wait counter and sticky error flags.
    // NOTE: every register here uses <= so all of them update from the same
    // pre-edge values; mixing in = would make results depend on statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
            bus_err  <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            // Cleared unless a request state is still waiting this cycle.
            wait_cnt <= '0;
            case (state)
                S_FETCH: begin
                    if (mem_ack) begin
                        state <= S_DECODE;
                    end else if (timeout_hit) begin
                        state   <= S_ERR;
                        bus_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_inc;
                    end
                end
                S_DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW:    state <= S_MEMADR;
                        OP_BEQ, OP_BNE:  state <= S_BRANCH;
                        OP_ADDI, OP_ORI: state <= S_IMMEX;
                        OP_J, OP_JAL:    state <= S_JUMP;
                        OP_RTYPE: begin
                            if (funct == FN_JR) begin
                                state <= S_JR;
                            end else if (funct_alu) begin
                                state <= S_EXEC;
                            end else begin
                                state   <= S_ERR;
                                illegal <= 1'b1;
                            end
                        end
                        default: begin
                            state   <= S_ERR;
                            illegal <= 1'b1;
                        end
                    endcase
                end
                S_MEMADR: state <= (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD: begin
                    if (mem_ack) begin
                        state <= S_MEMWB;
                    end else if (timeout_hit) begin
                        state   <= S_ERR;
                        bus_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_inc;
                    end
                end
                S_MEMWR: begin
                    if (mem_ack) begin
                        state <= S_FETCH;
                    end else if (timeout_hit) begin
                        state   <= S_ERR;
                        bus_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_inc;
                    end
                end
                S_EXEC:  state <= S_ALUWB;
                S_IMMEX: state <= S_IMMWB;
                S_MEMWB, S_ALUWB, S_IMMWB, S_BRANCH, S_JUMP, S_JR: state <= S_FETCH;
                S_ERR:   state <= S_ERR;
                // Unused codes are treated like a fault and parked in ERR.
                default: state <= S_ERR;
            endcase
        end
    end

    // Output decode from the registered state; reset suppresses every enable.
    // NOTE: all outputs get a default first so no path through the case
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = PCSRC_ALU;
        reg_we     = 1'b0;
        reg_dst    = DST_RT;
        mem_to_reg = WB_ALUOUT;
        alu_srca   = 1'b0;
        alu_srcb   = SRCB_RT;
        alu_op     = ALU_ADD;
        case (state)
            S_FETCH: begin
                mem_req  = 1'b1;
                alu_srcb = SRCB_FOUR;
                ir_we    = mem_ack;
                pc_we    = mem_ack;
            end
            S_DECODE: alu_srcb = SRCB_IMMSH;
            S_MEMADR: begin
                alu_srca = 1'b1;
                alu_srcb = SRCB_IMM;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWB: begin
                reg_we     = 1'b1;
                mem_to_reg = WB_MDR;
            end
            S_MEMWR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
            end
            S_EXEC: begin
                alu_srca = 1'b1;
                alu_op   = ALU_FUNCT;
            end
            S_ALUWB: begin
                reg_we  = 1'b1;
                reg_dst = DST_RD;
            end
            S_IMMEX: begin
                alu_srca = 1'b1;
                alu_srcb = SRCB_IMM;
                alu_op   = (opcode == OP_ORI) ? ALU_OR : ALU_ADD;
            end
            S_IMMWB: reg_we = 1'b1;
            S_BRANCH: begin
                alu_srca = 1'b1;
                alu_op   = ALU_SUB;
                pc_src   = PCSRC_ALUOUT;
                pc_we    = (opcode == OP_BNE) ? !zero : zero;
            end
            S_JUMP: begin
                pc_we  = 1'b1;
                pc_src = PCSRC_JUMP;
                // jal links PC (already PC+4) into $31 in the same cycle.
                if (opcode == OP_JAL) begin
                    reg_we     = 1'b1;
                    reg_dst    = DST_RA;
                    mem_to_reg = WB_PC;
                end
            end
            S_JR: begin
                pc_we  = 1'b1;
                pc_src = PCSRC_RS;
            end
            default: ;
        endcase
        if (rst) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
            ir_we   = 1'b0;
            pc_we   = 1'b0;
            reg_we  = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: instruction-level reference model for mc_ctrl. Each instruction
// is expanded into the cycle-by-cycle outputs the controller must show; a
// compare process checks the DUT against that script on every cycle.
module tb_mc_ctrl;

    localparam int unsigned TMO = 4;

    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3;
    localparam logic [3:0] S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_EXEC = 4'd6, S_ALUWB = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8, S_JUMP = 4'd9, S_IMMEX = 4'd10, S_IMMWB = 4'd11;
    localparam logic [3:0] S_JR = 4'd12, S_ERR = 4'd15;

    localparam logic [5:0] OP_RTYPE = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI = 6'b001101, OP_J = 6'b000010, OP_JAL = 6'b000011;
    localparam logic [5:0] FN_ADD = 6'b100000, FN_SUB = 6'b100010, FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR = 6'b100101, FN_SLT = 6'b101010, FN_JR = 6'b001000;

    typedef struct packed {
        logic       rst;
        logic       ack;
        logic       zero;
        logic [5:0] op;
        logic [5:0] fn;
        logic [3:0] st;
        logic       req;
        logic       we;
        logic       iord;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       reg_we;
        logic [1:0] reg_dst;
        logic [1:0] m2r;
        logic       srca;
        logic [1:0] srcb;
        logic [2:0] aluop;
        logic       bus_err;
        logic       illegal;
    } cyc_t;

    logic       clk = 1'b0;
    logic       rst, zero, mem_ack;
    logic [5:0] opcode, funct;
    logic       mem_req, mem_we, iord, ir_we, pc_we, reg_we, alu_srca, bus_err, illegal;
    logic [1:0] pc_src, reg_dst, mem_to_reg, alu_srcb;
    logic [2:0] alu_op;
    logic [3:0] state_o;

    mc_ctrl #(.MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
        .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_srca(alu_srca),
        .alu_srcb(alu_srcb), .alu_op(alu_op), .state_o(state_o),
        .bus_err(bus_err), .illegal(illegal)
    );

    always #5 clk = ~clk;

    cyc_t       exp_q[$];
    logic [3:0] obs_q[$];
    int         obs_pcwe, obs_memwe;
    int         n_checks = 0, n_pass = 0;
    logic [5:0] cur_op, cur_fn;
    logic       m_bus_err, m_illegal;

    logic [11:0] tbl [14] = '{
        {OP_RTYPE, FN_ADD}, {OP_RTYPE, FN_SUB}, {OP_RTYPE, FN_AND}, {OP_RTYPE, FN_OR},
        {OP_RTYPE, FN_SLT}, {OP_RTYPE, FN_JR},  {OP_LW, 6'd0},      {OP_SW, 6'd0},
        {OP_BEQ, 6'd0},     {OP_BNE, 6'd0},     {OP_ADDI, 6'd0},    {OP_ORI, 6'd0},
        {OP_J, 6'd0},       {OP_JAL, 6'd0}
    };

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    endtask

    // Per-cycle comparison of every output against the scripted expectation.
    always @(negedge clk) begin : cmp
        cyc_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("state", 32'(state_o), 32'(e.st));
            check("enables", 32'({mem_req, mem_we, ir_we, pc_we, reg_we}),
                  32'({e.req, e.we, e.ir_we, e.pc_we, e.reg_we}));
            check("selects", 32'({iord, pc_src, reg_dst, mem_to_reg, alu_srca, alu_srcb, alu_op}),
                  32'({e.iord, e.pc_src, e.reg_dst, e.m2r, e.srca, e.srcb, e.aluop}));
            check("sticky", 32'({bus_err, illegal}), 32'({e.bus_err, e.illegal}));
            obs_q.push_back(state_o);
            if (pc_we) obs_pcwe++;
            if (mem_we) obs_memwe++;
        end
    end

    // Base cycle: all outputs zero, ignored inputs randomized.
    function automatic cyc_t blank(input logic [3:0] st);
        cyc_t c;
        c         = '0;
        c.st      = st;
        c.op      = cur_op;
        c.fn      = cur_fn;
        c.ack     = 1'($urandom);
        c.zero    = 1'($urandom);
        c.bus_err = m_bus_err;
        c.illegal = m_illegal;
        return c;
    endfunction

    task automatic push(input cyc_t c);
        @(posedge clk);
        #1;
        rst     = c.rst;
        mem_ack = c.ack;
        zero    = c.zero;
        opcode  = c.op;
        funct   = c.fn;
        exp_q.push_back(c);
    endtask

    task automatic drain();
        if (exp_q.size() > 0) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clear_obs();
        obs_q.delete();
        obs_pcwe  = 0;
        obs_memwe = 0;
    endtask

    task automatic check_seq(input string name, input int n, input logic [63:0] want);
        check({name, "_len"}, 32'(obs_q.size()), 32'(n));
        for (int i = 0; i < n && i < obs_q.size(); i++)
            check({name, "_seq"}, 32'(obs_q[i]), 32'(want[4*(n-1-i) +: 4]));
    endtask

    // One reset cycle taken in whatever state c describes.
    task automatic do_reset(input cyc_t c);
        c.rst    = 1'b1;
        c.req    = 1'b0;
        c.we     = 1'b0;
        c.ir_we  = 1'b0;
        c.pc_we  = 1'b0;
        c.reg_we = 1'b0;
        push(c);
        m_bus_err = 1'b0;
        m_illegal = 1'b0;
    endtask

    // A request state waiting d cycles before ack; d >= TMO never acks.
    task automatic wait_phase(input logic [3:0] st, input int d, output bit to);
        cyc_t c;
        to = (d >= int'(TMO));
        for (int i = 0; i <= d && i < int'(TMO); i++) begin
            c     = blank(st);
            c.req = 1'b1;
            c.ack = (i == d);
            if (st == S_FETCH) begin
                c.srcb  = 2'd1;
                c.ir_we = c.ack;
                c.pc_we = c.ack;
            end else begin
                c.iord = 1'b1;
                c.we   = (st == S_MEMWR);
            end
            push(c);
        end
        if (to) m_bus_err = 1'b1;
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int fd, input int md, input bit rst_mem, output bit in_err);
        cyc_t c;
        bit   to;
        cur_op = op;
        cur_fn = fn;
        in_err = 1'b0;
        wait_phase(S_FETCH, fd, to);
        if (to) begin
            in_err = 1'b1;
            return;
        end
        c = blank(S_DECODE); c.srcb = 2'd3; push(c);
        case (op)
            OP_RTYPE: begin
                if (fn == FN_JR) begin
                    c = blank(S_JR); c.pc_we = 1'b1; c.pc_src = 2'd3; push(c);
                end else if (fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT}) begin
                    c = blank(S_EXEC); c.srca = 1'b1; c.aluop = 3'd2; push(c);
                    c = blank(S_ALUWB); c.reg_we = 1'b1; c.reg_dst = 2'd1; push(c);
                end else begin
                    m_illegal = 1'b1;
                    in_err    = 1'b1;
                end
            end
            OP_LW, OP_SW: begin
                c = blank(S_MEMADR); c.srca = 1'b1; c.srcb = 2'd2; push(c);
                if (rst_mem) begin
                    c = blank(op == OP_LW ? S_MEMRD : S_MEMWR);
                    c.iord = 1'b1;
                    do_reset(c);
                end else begin
                    wait_phase(op == OP_LW ? S_MEMRD : S_MEMWR, md, to);
                    if (to) in_err = 1'b1;
                    else if (op == OP_LW) begin
                        c = blank(S_MEMWB); c.reg_we = 1'b1; c.m2r = 2'd1; push(c);
                    end
                end
            end
            OP_BEQ, OP_BNE: begin
                c = blank(S_BRANCH);
                c.srca = 1'b1; c.aluop = 3'd1; c.pc_src = 2'd1; c.zero = z;
                c.pc_we = (op == OP_BEQ) ? z : ~z;
                push(c);
            end
            OP_ADDI, OP_ORI: begin
                c = blank(S_IMMEX); c.srca = 1'b1; c.srcb = 2'd2;
                c.aluop = (op == OP_ORI) ? 3'd3 : 3'd0;
                push(c);
                c = blank(S_IMMWB); c.reg_we = 1'b1; push(c);
            end
            OP_J, OP_JAL: begin
                c = blank(S_JUMP); c.pc_we = 1'b1; c.pc_src = 2'd2;
                if (op == OP_JAL) begin
                    c.reg_we = 1'b1; c.reg_dst = 2'd2; c.m2r = 2'd2;
                end
                push(c);
            end
            default: begin
                m_illegal = 1'b1;
                in_err    = 1'b1;
            end
        endcase
    endtask

    task automatic recover(input int n);
        for (int i = 0; i < n; i++) push(blank(S_ERR));
        do_reset(blank(S_ERR));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        cyc_t c;
        bit   e;
        rst = 1'b1; mem_ack = 1'b1; zero = 1'b0; opcode = '0; funct = '0;
        cur_op = OP_RTYPE; cur_fn = FN_ADD; m_bus_err = 1'b0; m_illegal = 1'b0;
        clear_obs();

        // Reset held across two edges; enables suppressed even with ack high.
        c = blank(S_FETCH); c.srcb = 2'd1; c.ack = 1'b1;
        do_reset(c);
        drain(); clear_obs();

        // add with immediate acks: 4 cycles, one PC write.
        run_instr(OP_RTYPE, FN_ADD, 1'b0, 0, 0, 1'b0, e);
        drain();
        check_seq("add", 4, 64'h0167);
        check("add_pcwe", 32'(obs_pcwe), 32'd1);

        // lw with 3 wait cycles in MEMRD: 8 cycles total.
        clear_obs();
        run_instr(OP_LW, 6'd0, 1'b0, 0, 3, 1'b0, e);
        drain();
        check_seq("lw", 8, 64'h01233334);

        // Branch taken/not taken.
        clear_obs();
        run_instr(OP_BEQ, 6'd0, 1'b1, 0, 0, 1'b0, e); drain();
        check("beq_z1_pcwe", 32'(obs_pcwe), 32'd2);
        clear_obs();
        run_instr(OP_BEQ, 6'd0, 1'b0, 0, 0, 1'b0, e); drain();
        check("beq_z0_pcwe", 32'(obs_pcwe), 32'd1);
        clear_obs();
        run_instr(OP_BNE, 6'd0, 1'b0, 0, 0, 1'b0, e); drain();
        check("bne_z0_pcwe", 32'(obs_pcwe), 32'd2);

        // jal and j both take 3 cycles.
        clear_obs();
        run_instr(OP_JAL, 6'd0, 1'b0, 0, 0, 1'b0, e);
        run_instr(OP_J, 6'd0, 1'b0, 0, 0, 1'b0, e);
        drain();
        check_seq("jal_j", 6, 64'h019019);

        // Fetch timeout, then reset and an ack exactly on the limit cycle.
        clear_obs();
        run_instr(OP_RTYPE, FN_ADD, 1'b0, TMO, 0, 1'b0, e);
        push(blank(S_ERR)); push(blank(S_ERR));
        drain();
        check_seq("timeout", 6, 64'h0000FF);
        do_reset(blank(S_ERR));
        drain(); clear_obs();
        run_instr(OP_RTYPE, FN_ADD, 1'b0, TMO - 1, 0, 1'b0, e);
        drain();
        check_seq("ack_on_limit", 7, 64'h0000167);

        // Illegal opcode and illegal funct.
        clear_obs();
        run_instr(6'b111111, 6'd0, 1'b0, 0, 0, 1'b0, e);
        push(blank(S_ERR)); drain();
        check_seq("bad_op", 3, 64'h01F);
        do_reset(blank(S_ERR));
        drain(); clear_obs();
        run_instr(OP_RTYPE, 6'b000000, 1'b0, 0, 0, 1'b0, e);
        push(blank(S_ERR)); drain();
        check_seq("bad_funct", 3, 64'h01F);
        do_reset(blank(S_ERR));

        // Reset in the middle of a store abandons it.
        drain(); clear_obs();
        run_instr(OP_SW, 6'd0, 1'b0, 0, 0, 1'b1, e);
        run_instr(OP_RTYPE, FN_ADD, 1'b0, 0, 0, 1'b0, e);
        drain();
        check_seq("rst_memwr", 8, 64'h01250167);
        check("rst_memwr_we", 32'(obs_memwe), 32'd0);

        // Randomized instruction stream with waits, timeouts and faults.
        for (int k = 0; k < 150; k++) begin
            logic [11:0] ent;
            logic [5:0]  op, fn;
            int          kind, fd, md;
            bit          rm;
            kind = $urandom_range(0, 19);
            ent  = tbl[$urandom_range(0, 13)];
            op   = ent[11:6];
            fn   = ent[5:0];
            fd   = $urandom_range(0, TMO - 1);
            md   = $urandom_range(0, TMO - 1);
            rm   = 1'b0;
            if (kind == 0) fd = TMO;
            else if (kind == 1) md = TMO;
            else if (kind == 2) rm = 1'b1;
            else if (kind == 3) begin
                if ($urandom_range(0, 1) == 0) begin
                    op = OP_RTYPE;
                    do fn = 6'($urandom);
                    while (fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_JR});
                end else begin
                    do op = 6'($urandom);
                    while (op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE,
                                      OP_ADDI, OP_ORI, OP_J, OP_JAL});
                end
            end
            run_instr(op, fn, 1'($urandom), fd, md, rm, e);
            if (e) recover($urandom_range(1, 3));
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
